// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch program-counter generator with stall/redirect/trap control
// Revision : 1.0
// ============================================================================
module pc_gen #(
    parameter int          XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          PC_INC       = 4,
    parameter int          ALIGN_BITS   = 2,
    parameter int          STALL_CNT_W  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_stall,
    input  logic                   i_redirect,
    input  logic [XLEN-1:0]        i_redirect_pc,
    input  logic                   i_trap,
    input  logic [XLEN-1:0]        i_trap_pc,
    output logic [XLEN-1:0]        o_pc,
    output logic [XLEN-1:0]        o_pc_seq,
    output logic                   o_pc_valid,
    output logic [STALL_CNT_W-1:0] o_stall_cnt,
    output logic                   o_misalign
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]        PC_STEP  = XLEN'(PC_INC);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};
    localparam logic [ALIGN_BITS-1:0]  ALIGN_Z  = '0;

    state_t                  state;
    state_t                  state_next;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         pc_next;
    logic [STALL_CNT_W-1:0]  stall_cnt;
    logic [STALL_CNT_W-1:0]  stall_cnt_next;
    logic                    misalign;
    logic                    misalign_next;
    logic [XLEN-1:0]         pc_seq;

    assign pc_seq = pc + PC_STEP;

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        stall_cnt_next = stall_cnt;
        misalign_next  = misalign;
        case (state)
            // First edge after reset only arms the fetch; the PC stays at the vector.
            BOOT: begin
                state_next = RUN;
            end
            RUN, HOLD: begin
                if (i_trap) begin
                    pc_next        = i_trap_pc;
                    stall_cnt_next = '0;
                    state_next     = RUN;
                end else if (i_redirect) begin
                    pc_next        = i_redirect_pc;
                    stall_cnt_next = '0;
                    state_next     = RUN;
                end else if (i_stall) begin
                    stall_cnt_next = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + 1'b1;
                    state_next     = HOLD;
                end else begin
                    pc_next        = pc_seq;
                    stall_cnt_next = '0;
                    state_next     = RUN;
                end
                // Any load recomputes the flag; a held PC keeps it.
                if (i_trap || i_redirect || !i_stall) begin
                    misalign_next = (pc_next[ALIGN_BITS-1:0] != ALIGN_Z);
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= BOOT;
            pc        <= RESET_VECTOR;
            stall_cnt <= '0;
            misalign  <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            stall_cnt <= stall_cnt_next;
            misalign  <= misalign_next;
        end
    end

    assign o_pc        = pc;
    assign o_pc_seq    = pc_seq;
    assign o_pc_valid  = (state != BOOT);
    assign o_stall_cnt = stall_cnt;
    assign o_misalign  = misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Directed self-checking bench for pc_gen (default parameters)
// Revision : 1.0
// ============================================================================
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic        pc_valid;
    logic [3:0]  stall_cnt;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    pc_gen dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_trap        (trap),
        .i_trap_pc     (trap_pc),
        .o_pc          (pc),
        .o_pc_seq      (pc_seq),
        .o_pc_valid    (pc_valid),
        .o_stall_cnt   (stall_cnt),
        .o_misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic e_valid,
                                input logic [3:0] e_cnt, input logic e_mis);
        check({tag, ".pc"},    pc,                e_pc);
        check({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
        check({tag, ".cnt"},   {28'd0, stall_cnt}, {28'd0, e_cnt});
        check({tag, ".mis"},   {31'd0, misalign}, {31'd0, e_mis});
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                         input logic t, input logic [31:0] tpc);
        stall = s; redirect = r; redirect_pc = rpc; trap = t; trap_pc = tpc;
    endtask

    initial begin
        // Reset and free run
        rst = 1'b1; tick();
        expect_state("reset", 32'h0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0; tick();
        expect_state("boot_exit", 32'h0, 1'b1, 4'd0, 1'b0);
        tick(); check("run1.pc", pc, 32'h4);
        tick(); check("run2.pc", pc, 32'h8);
        tick(); tick();
        check("run4.pc", pc, 32'h10);
        check("run4.seq", pc_seq, 32'h14);

        // Three-cycle stall then release
        drive(1, 0, 0, 0, 0);
        tick(); expect_state("stall1", 32'h10, 1'b1, 4'd1, 1'b0);
        tick(); expect_state("stall2", 32'h10, 1'b1, 4'd2, 1'b0);
        tick(); expect_state("stall3", 32'h10, 1'b1, 4'd3, 1'b0);
        drive(0, 0, 0, 0, 0);
        tick(); expect_state("release", 32'h14, 1'b1, 4'd0, 1'b0);

        // Long stall saturates the counter
        drive(1, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("long.pc", pc, 32'h14);
            check("long.cnt", {28'd0, stall_cnt}, (i > 15) ? 32'd15 : 32'(i));
        end
        drive(0, 0, 0, 0, 0);
        tick(); expect_state("long_rel", 32'h18, 1'b1, 4'd0, 1'b0);

        // Priority: trap beats redirect beats stall
        drive(1, 0, 0, 0, 0);
        tick(); tick();
        check("pre_trap.cnt", {28'd0, stall_cnt}, 32'd2);
        drive(1, 1, 32'h100, 1, 32'h80);
        tick(); expect_state("trap_prio", 32'h80, 1'b1, 4'd0, 1'b0);
        drive(1, 0, 0, 0, 0);
        tick(); tick();
        drive(1, 1, 32'h100, 0, 32'h80);
        tick(); expect_state("redir_prio", 32'h100, 1'b1, 4'd0, 1'b0);
        drive(0, 0, 0, 0, 0);
        tick(); check("after_redir.pc", pc, 32'h104);

        // Misalignment tracking
        drive(0, 1, 32'h102, 0, 0);
        tick(); expect_state("mis_set", 32'h102, 1'b1, 4'd0, 1'b1);
        drive(0, 0, 0, 0, 0);
        tick(); expect_state("mis_seq", 32'h106, 1'b1, 4'd0, 1'b1);
        drive(1, 0, 0, 0, 0);
        tick(); expect_state("mis_hold", 32'h106, 1'b1, 4'd1, 1'b1);
        drive(0, 1, 32'h200, 0, 0);
        tick(); expect_state("mis_clr", 32'h200, 1'b1, 4'd0, 1'b0);
        drive(0, 0, 0, 1, 32'h81);
        tick(); expect_state("mis_trap", 32'h81, 1'b1, 4'd0, 1'b1);
        drive(0, 0, 0, 0, 0);
        tick(); check("mis_trap_seq.pc", pc, 32'h85);
        check("mis_trap_seq.mis", {31'd0, misalign}, 32'd1);

        // Wrap at the top of the address space
        drive(0, 1, 32'hFFFF_FFFC, 0, 0);
        tick(); check("wrap_pre.pc", pc, 32'hFFFF_FFFC);
        check("wrap_pre.seq", pc_seq, 32'h0);
        drive(0, 0, 0, 0, 0);
        tick(); expect_state("wrap", 32'h0, 1'b1, 4'd0, 1'b0);

        // Reset aborts a stall, then BOOT ignores controls
        tick(); tick(); tick();
        drive(1, 0, 0, 0, 0);
        tick(); tick();
        check("pre_rst.cnt", {28'd0, stall_cnt}, 32'd2);
        check("pre_rst.pc", pc, 32'hC);
        rst = 1'b1;
        tick(); expect_state("rst_stall", 32'h0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        drive(1, 1, 32'h300, 1, 32'h3);
        tick(); expect_state("boot_ignore", 32'h0, 1'b1, 4'd0, 1'b0);
        drive(1, 0, 0, 0, 0);
        tick(); expect_state("post_boot_stall", 32'h0, 1'b1, 4'd1, 1'b0);
        drive(0, 0, 0, 0, 0);
        tick(); check("post_boot_run.pc", pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the PC value loaded by reset.
REQ-003 Parameter PC_INC, default 4, SHALL set the sequential increment.
REQ-004 Parameter ALIGN_BITS, default 2, SHALL set how many PC LSBs must be zero for an aligned PC.
REQ-005 Parameter STALL_CNT_W, default 4, SHALL set the stall-counter width.
REQ-006 Port i_clk, in, 1: the single clock; all state SHALL update on its rising edge only.
REQ-007 Port i_rst, in, 1: reset; synchronous, active-high.
REQ-008 Port i_stall, in, 1: hold the PC this cycle.
REQ-009 Port i_redirect, in, 1: load i_redirect_pc (branch/jump).
REQ-010 Port i_redirect_pc, in, XLEN: redirect target.
REQ-011 Port i_trap, in, 1: load i_trap_pc (exception entry).
REQ-012 Port i_trap_pc, in, XLEN: trap vector.
REQ-013 Port o_pc, out, XLEN: current registered PC.
REQ-014 Port o_pc_seq, out, XLEN: combinational o_pc + PC_INC, modulo 2^XLEN.
REQ-015 Port o_pc_valid, out, 1: o_pc is a fetchable address.
REQ-016 Port o_stall_cnt, out, STALL_CNT_W: consecutive stalled cycles, saturating.
REQ-017 Port o_misalign, out, 1: registered flag; the PC loaded at the last edge is misaligned.

Function
REQ-018 FSM states SHALL be BOOT, RUN and HOLD.
REQ-019 Next-PC priority at each edge, highest first, SHALL be: i_rst, i_trap, i_redirect, i_stall, sequential.
REQ-020 In RUN with no control input asserted, o_pc SHALL load o_pc_seq; the FSM SHALL stay in RUN.
REQ-021 i_trap SHALL load i_trap_pc, clear o_stall_cnt and go to RUN; this applies from RUN or HOLD, and i_stall and i_redirect are ignored that cycle.
REQ-022 i_redirect without i_trap SHALL load i_redirect_pc, clear o_stall_cnt and go to RUN; this applies even while i_stall=1.
REQ-023 i_stall alone SHALL hold o_pc, increment o_stall_cnt (saturating at all-ones) and go to or stay in HOLD.
REQ-024 Leaving HOLD with no control input SHALL load o_pc_seq of the held PC, clear o_stall_cnt and go to RUN.
REQ-025 Every stalled cycle SHALL hold o_pc; stalls of any length, including single-cycle stalls, SHALL hold.
REQ-026 PC increment SHALL wrap modulo 2^XLEN, with no flag raised.
REQ-027 o_misalign SHALL be set on the edge that loads a PC whose low ALIGN_BITS bits are nonzero, from any source.
REQ-028 o_misalign SHALL hold its value while stalled and SHALL be recomputed on every load.
REQ-029 o_pc_valid SHALL be 0 in BOOT and 1 in RUN and HOLD.
REQ-030 Latency from any control input to o_pc SHALL be one clock edge; o_pc_seq SHALL have zero latency.

Reset
REQ-031 While i_rst=1 at an edge: o_pc = RESET_VECTOR, o_stall_cnt = 0, o_misalign = 0, state = BOOT, o_pc_valid = 0; all other inputs ignored.
REQ-032 At the first edge with i_rst=0, BOOT SHALL go to RUN and hold o_pc at RESET_VECTOR, ignoring all other inputs.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL abort it; the next edge SHALL apply REQ-031 unconditionally.
REQ-034 Before the first reset, output values are undefined; the bench SHALL reset first.

Verification
REQ-035 Reset, then 3 free cycles: o_pc = 0x0 (valid 0), then 0x0, 0x4, 0x8 (valid 1).
REQ-036 At PC 0x10, stall 3 cycles then release: o_pc = 0x10 for 3 cycles, o_stall_cnt = 1, 2, 3, then o_pc = 0x14 and count 0.
REQ-037 Stall 20 cycles with STALL_CNT_W=4: o_stall_cnt saturates at 15, o_pc constant.
REQ-038 Same cycle i_stall=1, i_redirect=1 to 0x100, i_trap=1 to 0x80: o_pc = 0x80; repeat with i_trap=0: o_pc = 0x100, count 0.
REQ-039 Redirect to 0x102: o_misalign = 1 next cycle; then one sequential step to 0x106 keeps it 1; redirect to 0x200 clears it.
REQ-040 Redirect to 0xFFFF_FFFC, then one free cycle: o_pc = 0x0, o_pc_valid = 1; i_rst asserted during a stall: o_pc = RESET_VECTOR, o_stall_cnt = 0.
